// File: rtl/ddr_pi_code_ramp.sv
// PI code ramp controller: walks the registered code to an accepted target one LSB per step
// along the shortest path around the phase circle, so the decoder never sees phase jumps.
module ddr_pi_code_ramp #(
  parameter int unsigned CWIDTH = 6,
  parameter int unsigned DWIDTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bypass,
  input  logic [DWIDTH-1:0] i_step_dly,
  input  logic              i_target_vld,
  input  logic [CWIDTH-1:0] i_target_code,
  output logic              o_target_rdy,
  output logic [CWIDTH-1:0] o_code_bin,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CWIDTH-1:0] Half = CWIDTH'(1) << (CWIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e              state_q, state_d;
  logic [CWIDTH-1:0]   code_q, code_d;
  logic [CWIDTH-1:0]   tgt_q, tgt_d;
  logic [DWIDTH-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                busy_q;

  logic                accept;
  logic [CWIDTH-1:0]   diff;
  logic                step_up;
  logic [CWIDTH-1:0]   code_step;

  assign o_target_rdy = (state_q == StIdle) & i_en;
  assign accept       = i_target_vld & o_target_rdy;

  // Forward distance around the circle; a half-circle tie resolves upward.
  assign diff      = tgt_q - code_q;
  assign step_up   = (diff <= Half);
  assign code_step = step_up ? (code_q + CWIDTH'(1)) : (code_q - CWIDTH'(1));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!i_en) begin
      // Abort: code holds where it is, pending target is dropped.
      state_d = StIdle;
      tgt_d   = code_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tgt_d = i_target_code;
            cnt_d = i_step_dly;
            if (i_bypass) begin
              code_d = i_target_code;
              done_d = 1'b1;
            end else if (i_target_code == code_q) begin
              done_d = 1'b1;
            end else begin
              state_d = StRamp;
            end
          end
        end
        StRamp: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWIDTH'(1);
          end else begin
            code_d = code_step;
            cnt_d  = i_step_dly;
            if (code_step == tgt_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      code_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d == StRamp);
    end
  end

  assign o_code_bin = code_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

  // Completion and ramping are mutually exclusive.
  done_not_busy_a : assert property (@(posedge i_clk) disable iff (i_rst) !(o_done && o_busy));

endmodule

// File: tb/tb_ddr_pi_code_ramp.sv
// Self-checking bench: directed test-plan scenarios plus random traffic, checked every cycle
// against a model that precomputes each ramp as a per-cycle code schedule.
module tb_ddr_pi_code_ramp;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b0;
  logic       i_bypass = 1'b0;
  logic [3:0] i_step_dly = '0;
  logic       i_target_vld = 1'b0;
  logic [5:0] i_target_code = '0;
  logic       o_target_rdy;
  logic [5:0] o_code_bin;
  logic       o_busy;
  logic       o_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: current code, queue of codes to show on each following edge, done flag.
  int unsigned m_code = 0;
  int unsigned m_sched[$];
  bit          m_done = 1'b0;
  int unsigned cur_dly = 0;

  ddr_pi_code_ramp #(.CWIDTH(6), .DWIDTH(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_bypass      (i_bypass),
    .i_step_dly    (i_step_dly),
    .i_target_vld  (i_target_vld),
    .i_target_code (i_target_code),
    .o_target_rdy  (o_target_rdy),
    .o_code_bin    (o_code_bin),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_idle();
    return m_sched.size() == 0;
  endfunction

  // Plan a whole ramp: shortest way round (tie goes up), dly hold cycles before each step.
  function automatic void m_plan(input int unsigned tgt, input int unsigned dly);
    int unsigned up;
    int unsigned n;
    int unsigned c;
    bit          inc;
    up  = (tgt + 64 - m_code) % 64;
    inc = (up <= 32);
    n   = inc ? up : 64 - up;
    c   = m_code;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < dly; k++) m_sched.push_back(c);
      c = inc ? (c + 1) % 64 : (c + 63) % 64;
      m_sched.push_back(c);
    end
  endfunction

  // One clock cycle: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic cyc(input bit en, input bit byp, input int unsigned dly, input bit vld,
                     input int unsigned tc);
    bit rdy;
    i_en          = en;
    i_bypass      = byp;
    i_step_dly    = 4'(dly);
    i_target_vld  = vld;
    i_target_code = 6'(tc);
    #1;
    rdy = m_idle() && en;
    check_eq("target_rdy", 32'(o_target_rdy), 32'(rdy));
    @(posedge i_clk);
    m_done = 1'b0;
    if (!en) begin
      m_sched.delete();
    end else if (!m_idle()) begin
      m_code = m_sched.pop_front();
      m_done = m_idle();
    end else if (vld && rdy) begin
      cur_dly = dly;
      if (byp) begin
        m_code = tc;
        m_done = 1'b1;
      end else if (tc == m_code) begin
        m_done = 1'b1;
      end else begin
        m_plan(tc, dly);
      end
    end
    @(negedge i_clk);
    check_eq("code_bin", 32'(o_code_bin), m_code);
    check_eq("busy", 32'(o_busy), 32'(!m_idle()));
    check_eq("done", 32'(o_done), 32'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, cur_dly, 1'b0, 0);
  endtask

  task automatic reset_now();
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("rst_code", 32'(o_code_bin), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_done", 32'(o_done), 0);
    i_en = 1'b1;
    #1;
    check_eq("rst_rdy_en1", 32'(o_target_rdy), 1);
    i_en = 1'b0;
    #1;
    check_eq("rst_rdy_en0", 32'(o_target_rdy), 0);
    i_en = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    m_code = 0;
    m_sched.delete();
    m_done = 1'b0;
  endtask

  initial begin
    int guard;
    @(negedge i_clk);
    reset_now();

    // Up ramp 0 -> 5, no delay.
    cyc(1'b1, 1'b0, 0, 1'b1, 5);
    idle(6);
    check_eq("up_final", 32'(o_code_bin), 5);

    // Wrap-around 62 -> 2 with one idle cycle per step.
    cyc(1'b1, 1'b1, 0, 1'b1, 62);
    cyc(1'b1, 1'b0, 1, 1'b1, 2);
    idle(9);
    check_eq("wrap_final", 32'(o_code_bin), 2);

    // Down ramp 10 -> 7, dly 3.
    cyc(1'b1, 1'b1, 0, 1'b1, 10);
    cyc(1'b1, 1'b0, 3, 1'b1, 7);
    idle(13);
    check_eq("down_final", 32'(o_code_bin), 7);

    // Half-circle tie 0 -> 32 goes up.
    cyc(1'b1, 1'b1, 0, 1'b1, 0);
    cyc(1'b1, 1'b0, 0, 1'b1, 32);
    check_eq("tie_first", 32'(o_code_bin), 0);
    idle(1);
    check_eq("tie_dir", 32'(o_code_bin), 1);
    idle(33);

    // Bypass, then a no-op target equal to the current code.
    cyc(1'b1, 1'b1, 0, 1'b1, 3);
    cyc(1'b1, 1'b1, 2, 1'b1, 40);
    check_eq("byp_code", 32'(o_code_bin), 40);
    cyc(1'b1, 1'b0, 2, 1'b1, 40);
    idle(2);

    // Abort at 20 on a 0 -> 30 ramp, then resume.
    cyc(1'b1, 1'b1, 0, 1'b1, 0);
    cyc(1'b1, 1'b0, 0, 1'b1, 30);
    guard = 0;
    while (m_code != 20 && guard < 40) begin
      idle(1);
      guard++;
    end
    check_eq("abort_reach", 32'(o_code_bin), 20);
    cyc(1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 1'b0, 0);
    check_eq("abort_hold", 32'(o_code_bin), 20);
    cyc(1'b1, 1'b0, 0, 1'b1, 30);
    idle(12);
    check_eq("resume_final", 32'(o_code_bin), 30);

    // Target held valid during a ramp; taken only when ready returns.
    cyc(1'b1, 1'b0, 0, 1'b1, 10);
    for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 0, 1'b1, 50);
    idle(25);
    check_eq("held_final", 32'(o_code_bin), 50);

    // Reset in the middle of a ramp.
    cyc(1'b1, 1'b0, 1, 1'b1, 20);
    idle(5);
    reset_now();

    // Random traffic; delay only changes while idle.
    for (int i = 0; i < 3000; i++) begin
      bit          en;
      int unsigned dly;
      en  = ($urandom_range(0, 99) >= 4);
      dly = m_idle() ? $urandom_range(0, 3) : cur_dly;
      cyc(en, ($urandom_range(0, 9) == 0), dly, ($urandom_range(0, 3) == 0),
          $urandom_range(0, 63));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_pi_code_ramp.md
# ddr_pi_code_ramp

Sequential code controller directly upstream of the phase-interpolator binary-to-thermometer decoder. It accepts a 6-bit target PI code over a valid/ready handshake. It walks its registered output code toward the target one LSB at a time, at a programmable step interval, along the shortest path around the 64-code phase circle. The output feeds the decoder's 6-bit binary code input, so the interpolator never sees multi-LSB phase jumps during training or drift updates.

## Interface
- CWIDTH, 6: code width; the phase circle has 2^CWIDTH codes.
- DWIDTH, 4: width of the step-interval field.

- i_clk  input  1  block clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  block enable; deassertion aborts any ramp in progress.
- i_bypass  input  1  when 1, an accepted target loads directly with no ramp.
- i_step_dly  input  DWIDTH  idle cycles between steps; step period is i_step_dly+1 cycles. Sampled at accept and at every step.
- i_target_vld  input  1  target code valid.
- i_target_code  input  CWIDTH  requested PI code.
- o_target_rdy  output  1  block can accept a target.
- o_code_bin  output  CWIDTH  registered PI code to the decoder.
- o_busy  output  1  ramp in progress.
- o_done  output  1  one-cycle pulse when the output reaches the accepted target.

## Operation
- States: IDLE, RAMP.
- o_target_rdy = (state == IDLE) & i_en. It is combinational from state.
- Accept happens on a rising edge where i_target_vld & o_target_rdy.
  - At accept, tgt <= i_target_code and cnt <= i_step_dly.
  - If i_bypass = 1: o_code_bin <= i_target_code, o_done <= 1, and the block stays in IDLE.
  - Else if i_target_code == o_code_bin: o_done <= 1 and the block stays in IDLE.
  - Else: state <= RAMP.
- In RAMP, on each edge:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: take one step and reload cnt <= i_step_dly.
- Direction rule: diff = (tgt − o_code_bin) mod 2^CWIDTH.
  - If 1 ≤ diff ≤ 32: increment.
  - If diff > 32: decrement.
  - A tie (diff = 32) always increments.
- Arithmetic is modulo 2^CWIDTH: 63+1 gives 0, and 0−1 gives 63.
- Completion: if the stepped code equals tgt, then state <= IDLE and o_done <= 1 on the same edge.
- o_busy = (state == RAMP), registered.
- i_en = 0 in any state:
  - state <= IDLE on the next edge.
  - o_code_bin holds its current value.
  - No o_done pulse.
  - tgt is discarded.
- Targets presented while in RAMP are not accepted, because o_target_rdy = 0. The upstream source holds i_target_vld until ready.

## Timing
- Reset values:
  - o_code_bin = 0, o_busy = 0, o_done = 0.
  - state = IDLE, cnt = 0, tgt = 0.
  - o_target_rdy follows i_en during reset.
- Reset asserted mid-ramp immediately forces all of the above reset values, asynchronously.
- Accept to first code change: i_step_dly+1 cycles.
- Consecutive steps are i_step_dly+1 cycles apart.
- A ramp of N steps completes i_step_dly·N + N cycles after the accept edge.
- o_done is asserted in the cycle after the final step edge, coincident with o_code_bin == tgt and o_busy = 0. It lasts exactly one cycle.
- Earliest next accept: the same cycle that o_done is high, since o_target_rdy is already 1.
- Bypass and zero-distance accepts: o_done is high the cycle after accept. For bypass, o_code_bin updates on the accept edge.
- o_code_bin changes by exactly ±1 (mod 64) per step and never changes in a non-step cycle.

## Test plan
- Up ramp: code 0, target 5, dly 0 → o_code_bin reads 1,2,3,4,5 on five consecutive cycles; o_done is high for one cycle with code 5; o_busy is high for 5 cycles.
- Wrap-around: code 62, target 2, dly 1 → 63,0,1,2, one step every 2 cycles, no decrement; done after 8 cycles.
- Down ramp and tie:
  - Code 10, target 7, dly 3 → 9,8,7, four cycles apart.
  - Code 0, target 32 → 32 increments, never 63.
- Bypass and no-op:
  - i_bypass = 1, code 3, target 40 → code is 40 on the accept edge, done the next cycle, o_busy stays 0.
  - Target equal to the current code → done pulse only, code unchanged.
- Abort: i_en dropped after the code reaches 20 on a 0→30 ramp → code holds 20, state IDLE, no o_done; re-enable with target 30 → resumes 21..30.
- Handshake and reset:
  - i_target_vld held during RAMP → no accept until o_done.
  - i_rst asserted mid-ramp → o_code_bin = 0, o_busy = 0 immediately, and o_target_rdy follows i_en.
